// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BM_W   = 5;
  // Wide enough for ACCESS_CYCLES-1 and MAX_D_STREAK (both at most 15)
  localparam int unsigned CNT_W  = 4;

  // Whole-word access, no zero-extend: used for every instruction fetch
  localparam logic [BM_W-1:0] BYTEMODE_WORD = 5'b01111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_IF = 2'd1,
    ACC_D  = 2'd2
  } state_e;

  // One MMU access as presented on the shared port
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BM_W-1:0]   bytemode;
  } mmu_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single MMU port between instruction fetch and data memory.
// Data has priority; a saturating streak counter lets a waiting fetch in
// after MAX_D_STREAK consecutive data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned MAX_D_STREAK  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BM_W-1:0]   d_bytemode,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mmu_read,
  output logic              mmu_write,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [DATA_W-1:0] mmu_wdata,
  output logic [BM_W-1:0]   mmu_bytemode,
  input  logic [DATA_W-1:0] mmu_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_D_STREAK);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] streak_q;
  mmu_req_t         mmu_q;
  mmu_req_t         grant_req;
  logic             arb_point;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration: decide at IDLE or in the last cycle of an access
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    arb_point = (state_q == IDLE) || (cnt_q == '0);
    if (arb_point) begin
      state_d = IDLE;
      if (d_req && !(if_req && (streak_q == STREAK_MAX))) begin
        d_gnt   = 1'b1;
        state_d = ACC_D;
      end else if (if_req) begin
        if_gnt  = 1'b1;
        state_d = ACC_IF;
      end
    end
  end

  // Request bundle captured at the grant edge
  always_comb begin
    grant_req = '0;
    if (d_gnt) begin
      grant_req.read     = ~d_we;
      grant_req.write    = d_we;
      grant_req.addr     = d_addr;
      grant_req.wdata    = d_wdata;
      grant_req.bytemode = d_bytemode;
    end else if (if_gnt) begin
      grant_req.read     = 1'b1;
      grant_req.addr     = if_addr;
      grant_req.bytemode = BYTEMODE_WORD;
    end
  end

  // Latched MMU request and access-length countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmu_q <= '0;
      cnt_q <= '0;
    end else if (d_gnt || if_gnt) begin
      mmu_q <= grant_req;
      cnt_q <= CNT_LOAD;
    end else if (arb_point) begin
      mmu_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Completion: capture read data and pulse the matching rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (arb_point && (state_q == ACC_IF)) begin
        if_rvalid <= 1'b1;
        if_rdata  <= mmu_rdata;
      end
      if (arb_point && (state_q == ACC_D)) begin
        d_rvalid <= 1'b1;
        if (mmu_q.read) begin
          d_rdata <= mmu_rdata;
        end
      end
    end
  end

  // Consecutive data grants seen while a fetch waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (!if_req || if_gnt) begin
      streak_q <= '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_q <= streak_q + CNT_W'(1);
    end
  end

  assign mmu_read     = mmu_q.read;
  assign mmu_write    = mmu_q.write;
  assign mmu_addr     = mmu_q.addr;
  assign mmu_wdata    = mmu_q.wdata;
  assign mmu_bytemode = mmu_q.bytemode;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single MMU access port (SRAM/UART/LED bus) between the instruction-fetch stage and the data-memory stage.
- Latches one request at a time and holds the MMU strobes stable for ACCESS_CYCLES clocks.
- Returns registered read data with a one-cycle valid pulse.
- Data port has priority, with a bounded-streak rule so fetch cannot starve.

Parameters:
- ACCESS_CYCLES, 1: clocks each MMU access is held (1..15).
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch is pending (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request (level; held until if_gnt)
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  32  fetch data
- d_req  in  1  data request (level; held until d_gnt)
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_bytemode  in  5  MMU byte mode: [3:0] byte enables, [4] zero-extend
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data / write ack valid (1-cycle pulse)
- d_rdata  out  32  data read result
- mmu_read  out  1  MMU read strobe
- mmu_write  out  1  MMU write strobe
- mmu_addr  out  32  MMU address
- mmu_wdata  out  32  MMU write data
- mmu_bytemode  out  5  MMU byte mode
- mmu_rdata  in  32  MMU read data
- busy  out  1  access in progress

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs 0, including gnts, rvalids, rdata regs, mmu_*, busy.
  - Streak counter 0.
  - An access cut by reset is abandoned: no rvalid, no retry.
- FSM states: IDLE, ACC_IF, ACC_D.
- Arbitration point: IDLE, or the final cycle of an access (cnt == 0).
  - If d_req and not (if_req and streak == MAX_D_STREAK): d_gnt = 1, next state ACC_D.
  - Else if if_req: if_gnt = 1, next state ACC_IF.
  - Else: next state IDLE.
  - Gnt is combinational from the req inputs and state; at most one gnt per cycle.
- On grant, the following are registered at the same edge:
  - addr, wdata, we, bytemode.
  - Fetch uses bytemode 5'b01111 and we = 0.
  - cnt = ACCESS_CYCLES-1.
- In ACC_*:
  - mmu_* are driven from the registers only, never from live inputs.
  - mmu_read = ~we; mmu_write = we.
  - busy = 1.
  - cnt decrements each clock.
- Outside ACC_*: mmu_read = mmu_write = 0; mmu_addr, mmu_wdata and mmu_bytemode = 0.
- Completion, on the rising edge that ends the cycle with cnt == 0:
  - Reads: capture mmu_rdata into if_rdata or d_rdata.
  - Writes: d_rdata is left unchanged.
  - The matching rvalid is 1 for exactly the following cycle.
- Latency: grant cycle G; access occupies G+1..G+ACCESS_CYCLES; rvalid at G+ACCESS_CYCLES+1.
- Back-to-back: a grant issued in the final access cycle moves straight to the next ACC_* with no idle bubble. rvalid of the old access then overlaps the first cycle of the new one.
- Streak counter:
  - Increments on a d_gnt while if_req = 1, saturating at MAX_D_STREAK.
  - Clears on if_gnt, or on any cycle with if_req = 0.
- Simultaneous requests: data wins, except when the streak is saturated; then fetch wins once and the streak clears.
- A requester dropping req before gnt is legal; no access occurs.
- Addresses are forwarded unmodified; decoding, alignment and byte-lane steering belong to the MMU.
- d_rdata/if_rdata hold their last value until the next completion for that port.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/ACC_IF/ACC_D)
  - constant BYTEMODE_WORD = 5'b01111
  - constant ACCESS_CYCLES width
  - the MMU request bundle typedef (read, write, addr, wdata, bytemode)
- No sub-module: the arbitration priority function stays inline. A separate streak counter is not worth a module.

Test Plan:
- Single fetch, ACCESS_CYCLES=1: if_req=1, if_addr=32'h80000000 (mmu_rdata returns 32'h10000000) -> if_gnt same cycle; mmu_read=1, mmu_addr=32'h80000000, mmu_bytemode=5'b01111 next cycle; if_rvalid=1, if_rdata=32'h10000000 the cycle after.
- Data write: d_req=1, d_we=1, d_addr=32'hBFD00400, d_wdata=32'h0000A5A5, d_bytemode=5'b00011 -> mmu_write=1 with those values for exactly 1 cycle; d_rvalid pulse; mmu_read stays 0.
- Contention, MAX_D_STREAK=4, if_req and d_req held high -> grant order D,D,D,D,IF,D,D,D,D,IF; no idle cycle between accesses.
- ACCESS_CYCLES=3, data read of 32'h80400010 -> mmu_read held 3 cycles with stable addr; mmu_rdata captured only at the end of the third; d_rvalid 1 cycle later; new inputs during the access do not change mmu_addr.
- Reset mid-access: assert rst_n=0 in the second cycle of a 3-cycle read -> mmu_read=0 and busy=0 immediately; no d_rvalid after release; first grant after reset behaves as from IDLE.
- Request withdrawn: d_req pulsed for one cycle while an IF access is busy (not at its final cycle) -> no d_gnt, no MMU write, streak unchanged.
